// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared widths, address-region codes, slave indices and FSM encoding
// for the SoC slave-side bus decoder and its address decoder.
package soc_bus_pkg;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 19;
    localparam int NUM_SLAVES = 4;

    localparam logic [2:0] REG_RAM0   = 3'b000;
    localparam logic [2:0] REG_RAM1   = 3'b001;
    localparam logic [2:0] REG_FFT    = 3'b010;
    localparam logic [2:0] REG_CRYPTO = 3'b011;
    localparam logic [2:0] REG_GPIO   = 3'b100;

    localparam int SLV_RAM    = 0;
    localparam int SLV_FFT    = 1;
    localparam int SLV_CRYPTO = 2;
    localparam int SLV_GPIO   = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
endpackage

// File: rtl/soc_addr_decode.sv
// soc_addr_decode: maps the top three address bits to a one-hot slave select;
// hit is low for the unmapped regions.
module soc_addr_decode #(
    parameter int ADDR_W     = soc_bus_pkg::ADDR_W,
    parameter int NUM_SLAVES = soc_bus_pkg::NUM_SLAVES
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);
    import soc_bus_pkg::*;

    logic [2:0] region;

    assign region = addr[ADDR_W-1 -: 3];
    assign hit    = |sel;

    always_comb begin
        sel             = '0;
        sel[SLV_RAM]    = region == REG_RAM0 || region == REG_RAM1;
        sel[SLV_FFT]    = region == REG_FFT;
        sel[SLV_CRYPTO] = region == REG_CRYPTO;
        sel[SLV_GPIO]   = region == REG_GPIO;
    end
endmodule

// File: rtl/soc_bus_decoder.sv
// soc_bus_decoder: accepts one registered bus request, routes it to the decoded slave,
// waits for ready or timeout and returns a one-cycle done/err response with read data.
module soc_bus_decoder #(
    parameter int ADDR_W         = soc_bus_pkg::ADDR_W,
    parameter int DATA_W         = soc_bus_pkg::DATA_W,
    parameter int NUM_SLAVES     = soc_bus_pkg::NUM_SLAVES,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_valid,
    input  logic                         bus_write,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [ADDR_W-1:0]            bus_wdata,
    output logic                         bus_ready,
    output logic                         bus_done,
    output logic                         bus_err,
    output logic [DATA_W-1:0]            bus_rdata,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_write,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);
    import soc_bus_pkg::*;

    state_t                  state, next_state;
    logic [7:0]              cnt;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    hit, accept, sel_ready, timeout, finish;
    logic [DATA_W-1:0]       sel_rdata;

    soc_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) u_dec (
        .addr(bus_addr),
        .sel (dec_sel),
        .hit (hit)
    );

    assign accept    = state == ST_IDLE && bus_valid;
    assign sel_ready = |(s_sel & s_ready);
    assign timeout   = cnt == 8'(TIMEOUT_CYCLES - 1);
    assign finish    = state == ST_ACCESS && (sel_ready || timeout);

    // Masked AND-OR mux: unselected slices never reach bus_rdata, even when X.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel_rdata = sel_rdata | (s_sel[i] ? s_rdata[i*DATA_W +: DATA_W] : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state == ST_IDLE   ? (accept ? (hit ? ST_ACCESS : ST_RESP) : ST_IDLE) :
                     state == ST_ACCESS ? (finish ? ST_RESP : ST_ACCESS) :
                                          ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ready <= 1'b1;
            bus_done  <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            s_sel     <= '0;
            s_write   <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            cnt       <= '0;
        end else begin
            bus_ready <= next_state == ST_IDLE;
            bus_done  <= next_state == ST_RESP;
            bus_err   <= (accept && !hit) || (finish && !sel_ready);
            s_sel     <= accept ? dec_sel : (finish ? '0 : s_sel);
            cnt       <= accept ? '0 : (state == ST_ACCESS ? cnt + 8'd1 : cnt);
            if (accept) begin
                s_write <= bus_write;
                s_addr  <= bus_addr;
                s_wdata <= DATA_W'(bus_wdata);
            end
            // Reads complete with slave data on ready, or zero on miss/timeout.
            if ((accept && !hit && !bus_write) || (finish && !s_write))
                bus_rdata <= sel_ready ? sel_rdata : '0;
        end
    end
endmodule

// File: tb/tb_soc_bus_decoder.sv
// tb_soc_bus_decoder: directed and randomized accesses checked against a
// transaction-level model of the decoder's address map, latency and timeout rules.
module tb_soc_bus_decoder;
    import soc_bus_pkg::*;

    localparam int TO = 15;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         bus_valid, bus_write;
    logic [ADDR_W-1:0]            bus_addr, bus_wdata;
    logic                         bus_ready, bus_done, bus_err;
    logic [DATA_W-1:0]            bus_rdata;
    logic [NUM_SLAVES-1:0]        s_sel;
    logic                         s_write;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;

    int                total = 0;
    int                bad   = 0;
    logic [DATA_W-1:0] exp_rdata;

    soc_bus_decoder dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_done(bus_done), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .s_sel(s_sel), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int slave_of(input logic [ADDR_W-1:0] a);
        int r;
        r = int'(a >> 16);
        return r <= 1 ? 0 : (r <= 4 ? r - 1 : -1);
    endfunction

    // Slave s gets the given ready/data; every other slave gets random noise.
    task automatic drive_slaves(input int s, input bit rdy, input logic [DATA_W-1:0] d);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_ready[i] = (i == s) ? rdy : 1'($urandom);
            s_rdata[i*DATA_W +: DATA_W] = (i == s) ? d : DATA_W'($urandom);
        end
    endtask

    // One transaction; slave answers after `delay` wait cycles (>= TO means never).
    task automatic access(input bit wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] wd,
                          input logic [DATA_W-1:0] sd, input int delay);
        int                s, done_k, n;
        bit                err;
        logic [3:0]        oh;
        logic [DATA_W-1:0] d, cap;
        s      = slave_of(a);
        done_k = s < 0 ? 0 : (delay < TO ? delay : TO - 1) + 1;
        oh     = s < 0 ? 4'b0 : 4'(1 << s);
        err    = s < 0 || delay >= TO;
        cap    = '0;
        n      = 0;
        @(negedge clk);
        while (!bus_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", bus_ready, 1);
        bus_valid = 1; bus_write = wr; bus_addr = a; bus_wdata = wd;
        drive_slaves(-1, 0, '0);
        @(posedge clk); #1;
        bus_valid = 0; bus_write = 1'($urandom); bus_addr = ADDR_W'($urandom); bus_wdata = ADDR_W'($urandom);
        for (int k = 0; k <= done_k; k++) begin
            d = DATA_W'($urandom);
            if (k == delay) begin
                d   = sd;
                cap = sd;
            end
            drive_slaves(s, k == delay, d);
            @(negedge clk);
            check("s_sel", s_sel, k < done_k ? oh : 4'b0);
            check("bus_done", bus_done, k == done_k);
            check("bus_ready_busy", bus_ready, 0);
            if (k == 0) begin
                check("s_write", s_write, wr);
                check("s_addr", s_addr, a);
                check("s_wdata", s_wdata, wd);
            end
            if (k < done_k) begin
                @(posedge clk); #1;
            end
        end
        if (!wr) exp_rdata = err ? '0 : cap;
        check("bus_err", bus_err, err);
        check("bus_rdata", bus_rdata, exp_rdata);
        @(posedge clk); #1;
        drive_slaves(-1, 0, '0);
        @(negedge clk);
        check("post_ready", bus_ready, 1);
        check("post_done", bus_done, 0);
        check("post_err", bus_err, 0);
        check("post_rdata", bus_rdata, exp_rdata);
    endtask

    // bus_valid held high over three RAM reads with immediate ready.
    task automatic back_to_back();
        logic [ADDR_W-1:0] addrs [3];
        logic [DATA_W-1:0] prev;
        int                idx, ndone, last;
        bit                acc;
        addrs = '{19'h00000, 19'h10000, 19'h00004};
        idx = 0; ndone = 0; last = -1;
        @(negedge clk);
        bus_valid = 1; bus_write = 0; bus_addr = addrs[0];
        s_ready = 4'hF; s_rdata = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 15; c++) begin
            acc = bus_ready && idx < 3;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) bus_addr = addrs[idx];
                else         bus_valid = 0;
            end
            prev = s_rdata[DATA_W-1:0];
            s_rdata = {$urandom, $urandom, $urandom};
            @(negedge clk);
            if (bus_done) begin
                ndone++;
                if (last >= 0) check("b2b_gap", c - last, 3);
                last = c;
                check("b2b_rdata", bus_rdata, prev);
                check("b2b_err", bus_err, 0);
                exp_rdata = prev;
            end
        end
        check("b2b_count", ndone, 3);
        s_ready = '0;
    endtask

    initial begin
        rst = 1; bus_valid = 0; bus_write = 0; bus_addr = '0; bus_wdata = '0;
        s_ready = '0; s_rdata = '0; exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_ready", bus_ready, 1);
        check("rst_done", bus_done, 0);
        check("rst_err", bus_err, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_sel", s_sel, 0);
        check("rst_swrite", s_write, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_swdata", s_wdata, 0);

        access(0, 19'h20010, '0, 19'h01234, 0);
        access(1, 19'h40004, 19'h7ABCD, '0, 3);
        access(0, 19'h60000, '0, 19'h11111, 0);
        access(0, 19'h30000, '0, 19'h5A5A5, 100);
        access(0, 19'h30000, '0, 19'h2BEEF, 14);
        access(0, 19'h18000, '0, 19'h3C3C3, 13);
        back_to_back();

        // Reset in the middle of an FFT read aborts it.
        @(negedge clk);
        check("pre_rst_ready", bus_ready, 1);
        bus_valid = 1; bus_write = 0; bus_addr = 19'h20000; s_ready = '0;
        @(posedge clk); #1;
        bus_valid = 0;
        @(negedge clk);
        check("pre_rst_sel", s_sel, 4'b0010);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_rdata = '0;
        @(negedge clk);
        check("mid_rst_sel", s_sel, 0);
        check("mid_rst_ready", bus_ready, 1);
        check("mid_rst_done", bus_done, 0);
        check("mid_rst_rdata", bus_rdata, 0);
        access(0, 19'h20000, '0, 19'h4D4D4, 2);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                   $urandom_range(0, 3) == 0 ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/soc_bus_decoder.md
Name: soc_bus_decoder

Overview:
Slave-side stage directly downstream of the CPU bus interface register stage. Accepts one registered bus request at a time and decodes its 19-bit address into one of four slave regions: RAM, FFT accelerator, crypto accelerator and GPIO/timer. Holds the request to the selected slave until that slave signals ready, then returns read data, a done pulse and an error flag upstream. Unmapped addresses and slaves that never respond complete with an error.

Parameters:
ADDR_W, 19, address width
DATA_W, 19, data width
NUM_SLAVES, 4, number of decoded slave ports
TIMEOUT_CYCLES, 15, ACCESS cycles without slave ready before the access completes with an error (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
bus_valid  in  1  request valid from upstream register stage
bus_write  in  1  1=write, 0=read
bus_addr  in  ADDR_W  request address
bus_wdata  in  ADDR_W  write data
bus_ready  out  1  decoder can accept a request this cycle
bus_done  out  1  one-cycle completion pulse
bus_err  out  1  error qualifier, valid with bus_done
bus_rdata  out  DATA_W  read data, valid from bus_done onward
s_sel  out  NUM_SLAVES  one-hot slave select
s_write  out  1  registered write flag to slaves
s_addr  out  ADDR_W  registered address to slaves
s_wdata  out  DATA_W  registered write data to slaves
s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
s_ready  in  NUM_SLAVES  per-slave access-complete strobe

Behaviour:
- Reset (rst high at a clk edge) forces:
  - state=IDLE
  - bus_ready=1
  - bus_done=0, bus_err=0, bus_rdata=0
  - s_sel=0, s_write=0, s_addr=0, s_wdata=0
  - timeout counter=0
- Reset mid-access aborts the access; s_sel is 0 from the next edge.
- Address map on bus_addr[18:16]:
  - 000, 001 -> slave 0 (RAM)
  - 010 -> slave 1 (FFT)
  - 011 -> slave 2 (crypto)
  - 100 -> slave 3 (GPIO/timer)
  - 101..111 -> unmapped
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - bus_ready=1.
  - A request is accepted on an edge where bus_valid=1 and bus_ready=1. On that edge, s_write, s_addr and s_wdata are latched from the bus.
  - Mapped address -> s_sel=one-hot of the decoded slave, counter=0, go to ACCESS.
  - Unmapped address -> s_sel stays 0, go to RESP with err pending; a read also sets bus_rdata=0.
- ACCESS:
  - bus_ready=0; s_sel and the latched fields hold stable.
  - Each edge where s_ready[sel]=1: clear s_sel. For a read, capture the selected slice of s_rdata into bus_rdata. Go to RESP with err=0.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and s_ready[sel]=0: clear s_sel, set err, set bus_rdata=0 for a read, go to RESP.
  - If s_ready arrives on the same edge as the timeout limit, ready wins (no error).
  - s_ready bits of non-selected slaves are ignored.
- RESP:
  - bus_done=1 and bus_err valid for exactly one cycle; bus_ready=0.
  - Next edge: go to IDLE, with bus_done=0 and bus_err=0.
- Latency for a slave with zero wait:
  - accept edge E0;
  - s_sel high during cycle E0..E1; slave ready sampled at E1;
  - bus_done high during E1..E2.
  - Minimum request-to-done is 2 cycles; throughput is one access per 3 cycles.
- bus_rdata:
  - Updates only when a read completes (data or 0 on error).
  - Writes leave it unchanged; it holds its value between accesses.
- bus_valid while bus_ready=0 is ignored; upstream holds the request until bus_ready=1.
- No X propagation: unused s_rdata slices never reach bus_rdata.

Decomposition:
- Shared package soc_bus_pkg holds:
  - ADDR_W and DATA_W constants;
  - region codes (REG_RAM0, REG_RAM1, REG_FFT, REG_CRYPTO, REG_GPIO);
  - slave index constants (SLV_RAM=0, SLV_FFT=1, SLV_CRYPTO=2, SLV_GPIO=3);
  - state encoding (ST_IDLE, ST_ACCESS, ST_RESP).
- One combinational sub-module, soc_addr_decode: input addr; outputs one-hot sel[NUM_SLAVES-1:0] and hit. Reused by the DMA path later.

Test Plan:
- Read 0x20010 (FFT) with FFT s_ready=1 at the first ACCESS cycle -> s_sel=4'b0010 for 1 cycle; bus_done 2 cycles after accept; bus_rdata=FFT s_rdata=0x1234; bus_err=0.
- Write 0x40004 data 0x7ABCD, GPIO ready after 3 wait cycles -> s_sel=4'b1000 for 4 cycles; s_wdata=0x7ABCD; bus_done at cycle 5; bus_rdata unchanged; bus_err=0.
- Read 0x60000 (unmapped) -> s_sel never asserted; bus_done 1 cycle after accept; bus_err=1; bus_rdata=0.
- Read 0x30000 (crypto) with s_ready held low -> s_sel=4'b0100 for exactly 15 cycles; then bus_done=1, bus_err=1, bus_rdata=0. Repeat with s_ready pulsed on the 15th cycle -> bus_err=0 and data captured.
- bus_valid held high across 3 back-to-back RAM reads (addr 0x00000/0x10000/0x00004, ready immediate) -> accepts only when bus_ready=1; 3 done pulses 3 cycles apart; rdata sequence matches.
- rst asserted for 1 cycle during ACCESS of an FFT read -> next cycle s_sel=0, bus_ready=1, bus_done=0, bus_rdata=0; a fresh request then completes normally.
